stream_mux_n_rr: RTL and testbench
==================================

Name: stream_mux_n_rr

Overview:
- Parametrised N-channel stream multiplexer; successor to the combinational 2:1 and 4:1 muxes.
- Adds three things those muxes lack: per-channel valid/ready handshakes, a selectable fixed-priority or round-robin arbiter, and a one-entry registered output stage.
- Sits between several producer streams and a single consumer. The consumer sees one word per transfer, tagged with its source channel.

Parameters:
- N_CH, 4, number of input channels (≥1)
- W, 4, data width per channel in bits
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  N_CH  per-channel valid
- in_data  input  N_CH*W  flattened channel data; channel i occupies bits [i*W +: W]
- in_ready  output  N_CH  per-channel ready; at most one bit set per cycle
- out_valid  output  1  output register holds a word
- out_data  output  W  registered data word
- out_sel  output  SEL_W  source channel of out_data; SEL_W = max(1, $clog2(N_CH))
- out_ready  input  1  consumer accepts word

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - In-flight held word is discarded.
  - in_ready=0 while rst is high.
- load_en = !out_valid | out_ready. Output register may load when empty or being drained in the same cycle.
- Arbitration is combinational over in_valid:
  - Fixed mode: grant to the lowest i with in_valid[i]=1.
  - RR mode: search starts at ptr and wraps N_CH-1 → 0. Grant goes to the first valid channel found.
- in_ready = grant & {N_CH{load_en}}. in_ready depends on in_valid; no other channel's ready is asserted.
- Input transfer on channel i: in_valid[i] & in_ready[i].
  - Next edge: out_data ← channel i data, out_sel ← i, out_valid ← 1.
  - Latency is 1 cycle from input transfer to out_valid.
- Output transfer: out_valid & out_ready. If no input transfer occurs in the same cycle, out_valid ← 0 at the next edge.
- Simultaneous output transfer and input transfer: new word replaces old in the same edge. Full throughput of 1 word/cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel are held stable and all in_ready are 0.
- RR pointer:
  - On each input transfer from channel g, ptr ← g+1, wrapping N_CH-1 → 0.
  - ptr is unchanged when no transfer occurs.
  - ptr is unused when RR_MODE=0.
- No valid inputs: no grant, all in_ready=0, out_valid drains normally.
- N_CH=1: arbiter degenerates; in_ready[0]=load_en; out_sel is constant 0.
- Data on non-granted channels is ignored. Producers must hold data while valid and not ready.

Decomposition:
- Package stream_mux_pkg holds:
  - function clog2_min1(n), used to derive SEL_W
  - localparam defaults for N_CH and W
- Sub-module rr_arbiter (params N_CH, RR_MODE):
  - Inputs: clk, rst, req, advance.
  - Output: one-hot grant.
  - Contains the pointer register and the fixed/RR select.
- Top-level: load_en logic, one-hot-to-index encoder, data select, output register.

Test Plan:
- Reset mid-stream: load word 0xA from ch2, assert rst with out_ready=0 → out_valid=0, out_data=0, out_sel=0 immediately; after release, ch0 valid 0x3 → out_data=0x3, out_sel=0 one cycle later.
- RR fairness (RR_MODE=1, N_CH=4): all channels valid with data 0x1,0x2,0x3,0x4, out_ready=1 → out_sel sequence 0,1,2,3,0,1…; one word per cycle; no bubbles.
- Fixed priority (RR_MODE=0): ch1 and ch3 continuously valid → out_sel always 1; ch3 in_ready never asserted until ch1 valid drops.
- Backpressure: out_valid=1 with 0x5 from ch2, out_ready=0 for 3 cycles, ch0 valid → out_data/out_sel stable at 0x5/2 and in_ready=0; out_ready=1 → ch0 word appears next cycle.
- Wrap-around: ptr=3, only ch1 and ch3 valid → grant ch3, then ptr=0 → grant ch1, then ch3.
- Idle gaps: single ch2 pulse 0xF with out_ready=1 → out_valid high for exactly one cycle, then 0; no spurious transfers on idle inputs.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared defaults and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

  localparam int N_CH_DEFAULT = 4;
  localparam int W_DEFAULT    = 4;

  // A single channel still needs a one-bit select field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter with fixed-priority or round-robin selection.
// The pointer moves just past the granted channel on every accepted transfer.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH    = N_CH_DEFAULT,
  parameter bit RR_MODE = 1'b1,
  localparam int SEL_W  = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] gidx;
  int               idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      // Fixed priority is round-robin with the search always starting at 0.
      idx = RR_MODE ? ((int'(ptr_q) + k) % N_CH) : k;
      if (grant == '0 && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR_MODE && advance) begin
      ptr_d = (int'(gidx) == N_CH - 1) ? '0 : gidx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_n_rr.sv
// N-channel valid/ready stream multiplexer with arbitration and a one-entry
// registered output stage tagged with the source channel.
module stream_mux_n_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH    = N_CH_DEFAULT,
  parameter int W       = W_DEFAULT,
  parameter bit RR_MODE = 1'b1,
  localparam int SEL_W  = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic             load_en;
  logic             xfer;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gidx;
  logic [W-1:0]     gdata;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  rr_arbiter #(
    .N_CH    (N_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (xfer),
    .grant   (grant)
  );

  // The output slot can take a word when empty or when it drains this cycle.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    in_ready = rst ? '0 : (grant & {N_CH{load_en}});
    xfer     = |(in_valid & in_ready);
  end

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        gidx  = SEL_W'(i);
        gdata = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = gdata;
      out_sel_d  = gidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_n_rr.sv
// Directed bench for stream_mux_n_rr: a round-robin and a fixed-priority
// instance driven from vector tables plus a mid-stream reset sequence.
module tb_stream_mux_n_rr;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] dat;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_os;
    bit          chk_od;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  r_vld = '0;
  logic [15:0] r_dat = '0;
  logic [3:0]  r_rdy;
  logic        r_ov;
  logic [3:0]  r_od;
  logic [1:0]  r_os;
  logic        r_ordy = 1'b0;

  logic [3:0]  f_vld = '0;
  logic [15:0] f_dat = '0;
  logic [3:0]  f_rdy;
  logic        f_ov;
  logic [3:0]  f_od;
  logic [1:0]  f_os;
  logic        f_ordy = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_mux_n_rr #(.N_CH(4), .W(4), .RR_MODE(1'b1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_vld),
    .in_data   (r_dat),
    .in_ready  (r_rdy),
    .out_valid (r_ov),
    .out_data  (r_od),
    .out_sel   (r_os),
    .out_ready (r_ordy)
  );

  stream_mux_n_rr #(.N_CH(4), .W(4), .RR_MODE(1'b0)) dut_fx (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (f_vld),
    .in_data   (f_dat),
    .in_ready  (f_rdy),
    .out_valid (f_ov),
    .out_data  (f_od),
    .out_sel   (f_os),
    .out_ready (f_ordy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check in_ready before the rising
  // edge, then check the registered outputs just after it.
  task automatic run_vec(input bit fx, input string tag, input vec_t v);
    @(negedge clk);
    if (fx) begin
      f_vld = v.vld; f_dat = v.dat; f_ordy = v.ordy;
    end else begin
      r_vld = v.vld; r_dat = v.dat; r_ordy = v.ordy;
    end
    #1;
    chk({tag, " in_ready"}, fx ? 32'(f_rdy) : 32'(r_rdy), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, fx ? 32'(f_ov) : 32'(r_ov), 32'(v.exp_ov));
    if (v.chk_od) begin
      chk({tag, " out_data"}, fx ? 32'(f_od) : 32'(r_od), 32'(v.exp_od));
      chk({tag, " out_sel"},  fx ? 32'(f_os) : 32'(r_os), 32'(v.exp_os));
    end
  endtask

  vec_t rtbl[21];
  vec_t ftbl[7];
  vec_t v;

  initial begin
    // Round-robin: fairness, wrap-around, idle pulse, backpressure.
    rtbl[0]  = '{4'hF, 16'h4321, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1};
    rtbl[1]  = '{4'hF, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    rtbl[2]  = '{4'hF, 16'h4321, 1'b1, 4'h4, 1'b1, 4'h3, 2'd2, 1'b1};
    rtbl[3]  = '{4'hF, 16'h4321, 1'b1, 4'h8, 1'b1, 4'h4, 2'd3, 1'b1};
    rtbl[4]  = '{4'hF, 16'h4321, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1};
    rtbl[5]  = '{4'hF, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    rtbl[6]  = '{4'h4, 16'h4321, 1'b1, 4'h4, 1'b1, 4'h3, 2'd2, 1'b1};
    rtbl[7]  = '{4'hA, 16'h4321, 1'b1, 4'h8, 1'b1, 4'h4, 2'd3, 1'b1};
    rtbl[8]  = '{4'hA, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    rtbl[9]  = '{4'hA, 16'h4321, 1'b1, 4'h8, 1'b1, 4'h4, 2'd3, 1'b1};
    rtbl[10] = '{4'h0, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    rtbl[11] = '{4'h4, 16'h4F21, 1'b1, 4'h4, 1'b1, 4'hF, 2'd2, 1'b1};
    rtbl[12] = '{4'h0, 16'h4F21, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    rtbl[13] = '{4'h0, 16'h4F21, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    rtbl[14] = '{4'h4, 16'h4521, 1'b0, 4'h4, 1'b1, 4'h5, 2'd2, 1'b1};
    rtbl[15] = '{4'h1, 16'h4521, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2, 1'b1};
    rtbl[16] = '{4'h1, 16'h4521, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2, 1'b1};
    rtbl[17] = '{4'h1, 16'h4521, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2, 1'b1};
    rtbl[18] = '{4'h1, 16'h4521, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1};
    rtbl[19] = '{4'h0, 16'h4521, 1'b0, 4'h0, 1'b1, 4'h1, 2'd0, 1'b1};
    rtbl[20] = '{4'h0, 16'h4521, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};

    // Fixed priority: ch1 starves ch3 until ch1 drops.
    ftbl[0] = '{4'hA, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    ftbl[1] = '{4'hA, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    ftbl[2] = '{4'hA, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    ftbl[3] = '{4'hA, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1};
    ftbl[4] = '{4'h8, 16'h4321, 1'b1, 4'h8, 1'b1, 4'h4, 2'd3, 1'b1};
    ftbl[5] = '{4'hF, 16'h4321, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1};
    ftbl[6] = '{4'h0, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};

    // Reset state, with requests pending.
    r_vld = 4'hF;
    r_dat = 16'h4321;
    @(negedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(r_rdy), 32'h0);
    chk("reset out_valid", 32'(r_ov), 32'h0);
    chk("reset out_data", 32'(r_od), 32'h0);
    chk("reset out_sel", 32'(r_os), 32'h0);
    chk("reset fx out_valid", 32'(f_ov), 32'h0);
    rst   = 1'b0;
    r_vld = '0;

    for (int i = 0; i < 21; i++) run_vec(1'b0, $sformatf("rr[%0d]", i), rtbl[i]);
    for (int i = 0; i < 7; i++)  run_vec(1'b1, $sformatf("fx[%0d]", i), ftbl[i]);

    // Mid-stream reset discards a held word and clears the pointer.
    v = '{4'h4, 16'h0A00, 1'b0, 4'h4, 1'b1, 4'hA, 2'd2, 1'b1};
    run_vec(1'b0, "mid load", v);
    @(negedge clk);
    r_vld = 4'hF;
    rst   = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(r_ov), 32'h0);
    chk("mid rst out_data", 32'(r_od), 32'h0);
    chk("mid rst out_sel", 32'(r_os), 32'h0);
    chk("mid rst in_ready", 32'(r_rdy), 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    r_vld = '0;
    v = '{4'hF, 16'h4323, 1'b1, 4'h1, 1'b1, 4'h3, 2'd0, 1'b1};
    run_vec(1'b0, "post rst", v);
    v = '{4'h0, 16'h4323, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    run_vec(1'b0, "post rst drain", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
